// File: rtl/logicnet_sched_pkg.sv
// Shared types and width helpers for the LogicNets layer scheduler.
package logicnet_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE
    } state_t;

    localparam logic CFG_SEL_TABLE = 1'b0;
    localparam logic CFG_SEL_CONN  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned pw;
        r  = 0;
        pw = 1;
        while (pw < v) begin
            pw = pw << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned lut_aw(input int unsigned fanin, input int unsigned in_bw);
        return fanin * in_bw;
    endfunction

    function automatic int unsigned cfg_dw(input int unsigned out_bw, input int unsigned fi);
        return (out_bw > fi) ? out_bw : fi;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Truth-table store: single-port RAM with synchronous write and registered read.
module lut_table_ram #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/logicnet_layer_scheduler.sv
// Time-multiplexed LogicNets layer: one neuron per cycle through a shared,
// runtime-loadable truth-table RAM with a flop-based connectivity map.
module logicnet_layer_scheduler
    import logicnet_sched_pkg::*;
#(
    parameter int unsigned IN_FEATS  = 8,
    parameter int unsigned IN_BW     = 2,
    parameter int unsigned FANIN     = 3,
    parameter int unsigned OUT_BW    = 2,
    parameter int unsigned N_NEURONS = 8,
    localparam int unsigned LA     = lut_aw(FANIN, IN_BW),
    localparam int unsigned NI     = clog2(N_NEURONS),
    localparam int unsigned CFG_AW = NI + LA,
    localparam int unsigned FI     = clog2(IN_FEATS),
    localparam int unsigned CFG_DW = cfg_dw(OUT_BW, FI)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic                          cfg_sel,
    input  logic [CFG_AW-1:0]             cfg_addr,
    input  logic [CFG_DW-1:0]             cfg_wdata,
    output logic                          cfg_err,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IN_FEATS*IN_BW-1:0]     s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [N_NEURONS*OUT_BW-1:0]   m_data,
    output logic                          busy
);

    localparam int unsigned NC = N_NEURONS * FANIN;
    localparam int unsigned CI = clog2(NC);

    state_t                    state, state_nx;
    logic [NI:0]               idx;
    logic [NI-1:0]             wb_slot;
    logic [IN_FEATS*IN_BW-1:0] in_reg;
    logic [FI-1:0]             conn [NC];
    logic [CI-1:0]             conn_base;
    logic [FI-1:0]             feat_sel;
    logic [FI-1:0]             feat_idx;
    logic [LA-1:0]             lut_addr;
    logic [CFG_AW-1:0]         ram_addr;
    logic [OUT_BW-1:0]         ram_rdata;
    logic                      ram_we;
    logic                      in_idle;
    logic                      accept;

    assign in_idle = (state == ST_IDLE);
    assign s_ready = in_idle & ~cfg_we;
    assign accept  = s_valid & s_ready;
    assign busy    = ~in_idle;
    assign m_valid = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (accept) state_nx = ST_EVAL;
            ST_EVAL: if (idx == (NI+1)'(N_NEURONS)) state_nx = ST_DONE;
            ST_DONE: if (m_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // idx runs one past the last neuron: that extra cycle retires slot N-1 from the RAM register.
    assign wb_slot = idx[NI-1:0] - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            in_reg  <= '0;
            m_data  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~in_idle;
            if (accept) begin
                in_reg <= s_data;
                idx    <= '0;
            end else if (state == ST_EVAL) begin
                idx <= idx + 1'b1;
                if (idx != '0) begin
                    m_data[wb_slot*OUT_BW +: OUT_BW] <= ram_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && in_idle && (cfg_sel == CFG_SEL_CONN) && (cfg_addr < CFG_AW'(NC))) begin
            conn[cfg_addr[CI-1:0]] <= cfg_wdata[FI-1:0];
        end
    end

    assign conn_base = CI'(idx[NI-1:0] * FANIN);

    // Out-of-range feature indices fall back to feature 0 so the address is always defined.
    always_comb begin
        lut_addr = '0;
        feat_sel = '0;
        feat_idx = '0;
        for (int unsigned k = 0; k < FANIN; k++) begin
            feat_sel = conn[conn_base + CI'(k)];
            feat_idx = (int'(feat_sel) < int'(IN_FEATS)) ? feat_sel : '0;
            lut_addr[k*IN_BW +: IN_BW] = in_reg[int'(feat_idx)*IN_BW +: IN_BW];
        end
    end

    assign ram_we   = cfg_we & in_idle & (cfg_sel == CFG_SEL_TABLE);
    assign ram_addr = in_idle ? cfg_addr : {idx[NI-1:0], lut_addr};

    lut_table_ram #(
        .AW (CFG_AW),
        .DW (OUT_BW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cfg_wdata[OUT_BW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_logicnet_layer_scheduler.sv
// Randomised bench for logicnet_layer_scheduler against a transaction-level layer model.
module tb_logicnet_layer_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic        cfg_sel;
    logic [8:0]  cfg_addr;
    logic [2:0]  cfg_wdata;
    logic        cfg_err;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int tbl_m  [512];
    int conn_m [24];

    bit          inflight  = 1'b0;
    bit          err_m     = 1'b0;
    int          cyc       = 0;
    int          acc_cyc   = 0;
    logic [15:0] exp_data  = '0;
    logic [15:0] idle_data = '0;

    bit rand_ready = 1'b0;
    bit mr_forced  = 1'b1;

    logicnet_layer_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lut_of(input int n, input logic [15:0] d);
        int a = 0;
        for (int k = 0; k < 3; k++) begin
            int f = conn_m[n*3 + k];
            if (f >= 8) f = 0;
            a = a | (int'((d >> (2*f)) & 16'h3) << (2*k));
        end
        return a;
    endfunction

    function automatic logic [15:0] model_eval(input logic [15:0] d);
        int r = 0;
        for (int n = 0; n < 8; n++) begin
            r = r | (tbl_m[n*64 + lut_of(n, d)] << (2*n));
        end
        return 16'(r);
    endfunction

    // Transaction-level model: an accepted vector is in flight for 9 edges, then held until taken.
    always @(posedge clk) begin
        bit was_in;
        bit mv;
        if (rst) begin
            inflight  = 1'b0;
            err_m     = 1'b0;
            idle_data = '0;
        end else begin
            was_in = inflight;
            mv     = inflight && (cyc >= acc_cyc + 9);
            err_m  = cfg_we && was_in;
            if (cfg_we && !was_in) begin
                if (cfg_sel == 1'b0) tbl_m[int'(cfg_addr)] = int'(cfg_wdata[1:0]);
                else if (cfg_addr < 9'd24) conn_m[int'(cfg_addr)] = int'(cfg_wdata);
            end
            if (mv && m_ready) begin
                inflight  = 1'b0;
                idle_data = exp_data;
            end
            if (!was_in && !cfg_we && s_valid) begin
                inflight = 1'b1;
                acc_cyc  = cyc + 1;
                exp_data = model_eval(s_data);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit mv;
        if (!rst) begin
            mv = inflight && (cyc >= acc_cyc + 9);
            chk("m_valid", 32'(m_valid), 32'(mv));
            chk("busy", 32'(busy), 32'(inflight));
            chk("s_ready", 32'(s_ready), 32'(!inflight && !cfg_we));
            chk("cfg_err", 32'(cfg_err), 32'(err_m));
            if (mv) chk("m_data", 32'(m_data), 32'(exp_data));
            else if (!inflight) chk("m_data_hold", 32'(m_data), 32'(idle_data));
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : mr_forced;
        end
    end

    task automatic cfg_wr(input logic sel, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 9'(addr);
        cfg_wdata = 3'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        bit ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'(ok), 32'(1));
    endtask

    task automatic wait_mvalid(output logic [15:0] d, output int n);
        n = 0;
        while (!m_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!m_valid) chk("result_timeout", 32'(m_valid), 32'(1));
        d = m_data;
    endtask

    task automatic load_identity();
        wait_idle();
        for (int n = 0; n < 8; n++) begin
            cfg_wr(1'b1, n*3,     n);
            cfg_wr(1'b1, n*3 + 1, 0);
            cfg_wr(1'b1, n*3 + 2, 0);
        end
        for (int a = 0; a < 512; a++) cfg_wr(1'b0, a, a & 3);
    endtask

    initial begin
        logic [15:0] d, d0, v, expv;
        int          n, la, oldv, nv;

        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_s_ready", 32'(s_ready), 32'(1));
        chk("init_m_valid", 32'(m_valid), 32'(0));
        chk("init_m_data", 32'(m_data), 32'(0));
        @(posedge clk); #1;

        // identity layer
        load_identity();
        chk("model_identity", 32'(model_eval(16'hE4E4)), 32'h0000_E4E4);
        send(16'hE4E4);
        wait_mvalid(d, n);
        chk("identity_latency", 32'(n), 32'(9));
        chk("identity_data", 32'(d), 32'h0000_E4E4);

        // constant / mask table
        wait_idle();
        for (int a = 0; a < 512; a++) cfg_wr(1'b0, a, (a == 3*64) ? 3 : 0);
        chk("model_mask", 32'(model_eval(16'h0000)), 32'h0000_00C0);
        send(16'h0000);
        wait_mvalid(d, n);
        chk("mask_zero", 32'(d), 32'h0000_00C0);
        send(16'h0001);
        wait_mvalid(d, n);
        chk("mask_one", 32'(d), 32'h0000_0000);

        // random tables and connectivity
        wait_idle();
        for (int a = 0; a < 512; a++) cfg_wr(1'b0, a, $urandom_range(0, 3));
        for (int a = 0; a < 24; a++)  cfg_wr(1'b1, a, $urandom_range(0, 7));

        // backpressure
        wait_idle();
        mr_forced = 1'b0;
        send(16'($urandom));
        wait_mvalid(d0, n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_m_valid", 32'(m_valid), 32'(1));
            chk("bp_m_data", 32'(m_data), 32'(d0));
            chk("bp_s_ready", 32'(s_ready), 32'(0));
        end
        mr_forced = 1'b1;
        v = 16'($urandom);
        send(v);
        wait_mvalid(d, n);
        chk("bp_next", 32'(d), 32'(model_eval(v)));

        // illegal config during EVAL cycle 2
        wait_idle();
        v = 16'($urandom);
        expv = model_eval(v);
        send(v);
        repeat (2) begin @(posedge clk); #1; end
        la = lut_of(5, v);
        oldv = tbl_m[5*64 + la];
        cfg_wr(1'b0, 5*64 + la, oldv ^ 3);
        chk("illegal_err_pulse", 32'(cfg_err), 32'(1));
        @(posedge clk); #1;
        chk("illegal_err_clear", 32'(cfg_err), 32'(0));
        wait_mvalid(d, n);
        chk("illegal_cur", 32'(d), 32'(expv));
        send(v);
        wait_mvalid(d, n);
        chk("illegal_next", 32'(d), 32'(expv));

        // config write colliding with s_valid
        wait_idle();
        v  = 16'($urandom);
        la = lut_of(2, v);
        nv = tbl_m[2*64 + la] ^ 1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 9'(2*64 + la); cfg_wdata = 3'(nv);
        s_valid = 1'b1; s_data = v;
        @(negedge clk);
        chk("collide_s_ready_low", 32'(s_ready), 32'(0));
        @(posedge clk); #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("collide_s_ready_next", 32'(s_ready), 32'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        chk("collide_busy", 32'(busy), 32'(1));
        wait_mvalid(d, n);
        chk("collide_result", 32'(d), 32'(model_eval(v)));
        chk("collide_slot2", 32'(d[5:4]), 32'(nv));

        // asynchronous reset in EVAL cycle 3
        wait_idle();
        send(16'($urandom));
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_cfg_err", 32'(cfg_err), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'(1));
        v = 16'($urandom);
        send(v);
        wait_mvalid(d, n);
        chk("rst_after", 32'(d), 32'(model_eval(v)));

        // random traffic with random backpressure and stray config writes
        wait_idle();
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) cfg_wr(1'b1, $urandom_range(0, 23), $urandom_range(0, 7));
                else cfg_wr(1'b0, $urandom_range(0, 511), $urandom_range(0, 3));
            end
            send(16'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        wait_idle();
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
